// File: rtl/accel_uart_word_tx.sv
// accel_uart_word_tx
// Sends each 16-bit word from the accelerometer FIFO manager as two 8N1 UART
// frames. wordComplete pulses when the second stop bit ends, which makes the
// manager advance to its next word. The settle phase waits out the manager's
// two-register lag before i_Word is sampled.
module accel_uart_word_tx #(
    parameter int CLKS_PER_BIT    = 868,
    parameter int SETTLE_CYCLES   = 2,
    parameter bit HIGH_BYTE_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_Enable,
    input  logic [15:0] i_Word,
    output logic        o_Tx,
    output logic        wordComplete,
    output logic        o_Busy,
    output logic        o_Byte_Index
);

    localparam int BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [BAUD_W-1:0]   BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          bit_reg, bit_next;
    logic [SETTLE_W-1:0] settle_reg, settle_next;
    logic [15:0]         word_reg, word_next;
    logic                byte_idx_reg, byte_idx_next;
    logic                tx_reg, tx_next;
    logic                wc_reg, wc_next;
    logic                busy_reg, busy_next;

    logic [7:0] first_byte;
    logic [7:0] second_byte;
    logic [7:0] cur_byte;
    logic [2:0] bit_inc;
    logic       baud_done;

    // Map the latched word onto the two frames in the configured byte order.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte_map
            if (HIGH_BYTE_FIRST) begin : g_high_first
                assign first_byte[gi]  = word_reg[8 + gi];
                assign second_byte[gi] = word_reg[gi];
            end else begin : g_low_first
                assign first_byte[gi]  = word_reg[gi];
                assign second_byte[gi] = word_reg[8 + gi];
            end
        end
    endgenerate

    assign cur_byte  = byte_idx_reg ? second_byte : first_byte;
    assign bit_inc   = bit_reg + 3'd1;
    assign baud_done = (baud_reg == BAUD_LAST);

    // Next-state and next-output logic; outputs are computed one edge ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_next      = bit_reg;
        settle_next   = settle_reg;
        word_next     = word_reg;
        byte_idx_next = byte_idx_reg;
        tx_next       = tx_reg;
        wc_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (i_Enable) begin
                    state_next  = SETTLE;
                    settle_next = '0;
                end
            end
            SETTLE: begin
                tx_next = 1'b1;
                if (settle_reg == SETTLE_LAST) begin
                    // DataOut is stable now: capture it and open the first frame.
                    word_next     = i_Word;
                    byte_idx_next = 1'b0;
                    baud_next     = '0;
                    tx_next       = 1'b0;
                    state_next    = START;
                end else begin
                    settle_next = settle_reg + SETTLE_W'(1);
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    tx_next    = cur_byte[0];
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_inc;
                        tx_next  = cur_byte[bit_inc];
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (!byte_idx_reg) begin
                        // Second frame follows with no idle gap.
                        byte_idx_next = 1'b1;
                        tx_next       = 1'b0;
                        state_next    = START;
                    end else begin
                        wc_next     = 1'b1;
                        tx_next     = 1'b1;
                        settle_next = '0;
                        state_next  = i_Enable ? SETTLE : IDLE;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers with synchronous reset; a reset mid-frame
    // simply drops the frame and lets the line float back high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= 3'd0;
            settle_reg   <= '0;
            word_reg     <= 16'h0000;
            byte_idx_reg <= 1'b0;
            tx_reg       <= 1'b1;
            wc_reg       <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            settle_reg   <= settle_next;
            word_reg     <= word_next;
            byte_idx_reg <= byte_idx_next;
            tx_reg       <= tx_next;
            wc_reg       <= wc_next;
            busy_reg     <= busy_next;
        end
    end

    assign o_Tx         = tx_reg;
    assign wordComplete = wc_reg;
    assign o_Busy       = busy_reg;
    assign o_Byte_Index = byte_idx_reg;

endmodule
